// File: rtl/result_arbiter.sv
// Result arbiter: per-source result FIFOs drained onto NUM_BUS completion buses
// with rotating round-robin priority, plus flash and per-source backpressure.
module result_arbiter #(
  parameter int unsigned NUM_SRC = 5,
  parameter int unsigned NUM_BUS = 2,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ID_W    = 8,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            flash,
  input  logic [NUM_SRC-1:0]              src_valid,
  input  logic [NUM_SRC*ID_W-1:0]         src_id,
  input  logic [NUM_SRC*DATA_W-1:0]       src_data,
  output logic [NUM_SRC-1:0]              src_ready,
  output logic [NUM_BUS-1:0]              cmp_valid,
  output logic [NUM_BUS*ID_W-1:0]         cmp_id,
  output logic [NUM_BUS*DATA_W-1:0]       cmp_data,
  output logic [NUM_BUS*$clog2(NUM_SRC)-1:0] cmp_src
);

  localparam int unsigned SRC_W = $clog2(NUM_SRC);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned NB_W  = $clog2(NUM_BUS + 1);

  logic [ID_W-1:0]   mem_id   [NUM_SRC][DEPTH];
  logic [DATA_W-1:0] mem_data [NUM_SRC][DEPTH];
  logic [PTR_W-1:0]  rptr [NUM_SRC];
  logic [PTR_W-1:0]  wptr [NUM_SRC];
  logic [CNT_W-1:0]  cnt  [NUM_SRC];
  logic [SRC_W-1:0]  rr_ptr;

  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] grant;
  logic [ID_W-1:0]    head_id   [NUM_SRC];
  logic [DATA_W-1:0]  head_data [NUM_SRC];
  logic [NUM_BUS-1:0] bus_used;
  logic [SRC_W-1:0]   bus_sel [NUM_BUS];
  logic [SRC_W-1:0]   next_rr;
  logic [NB_W-1:0]    nb;
  logic [SRC_W:0]     pos;
  logic [SRC_W-1:0]   idx;

  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = (cnt[i] != CNT_W'(DEPTH));
      head_id[i]   = mem_id[i][rptr[i]];
      head_data[i] = mem_data[i][rptr[i]];
    end
  end

  assign push = src_valid & src_ready;

  // Cyclic scan from rr_ptr; the k-th non-empty source found is routed to bus k.
  always_comb begin
    grant    = '0;
    bus_used = '0;
    next_rr  = rr_ptr;
    nb       = '0;
    pos      = '0;
    idx      = '0;
    for (int unsigned b = 0; b < NUM_BUS; b++) bus_sel[b] = '0;
    for (int unsigned j = 0; j < NUM_SRC; j++) begin
      pos = {1'b0, rr_ptr} + (SRC_W+1)'(j);
      if (pos >= (SRC_W+1)'(NUM_SRC)) pos = pos - (SRC_W+1)'(NUM_SRC);
      idx = pos[SRC_W-1:0];
      if ((cnt[idx] != '0) && (nb < NB_W'(NUM_BUS))) begin
        grant[idx]   = 1'b1;
        bus_sel[nb]  = idx;
        bus_used[nb] = 1'b1;
        nb           = nb + NB_W'(1);
        next_rr      = (idx == SRC_W'(NUM_SRC - 1)) ? '0 : idx + SRC_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (reset && !flash && push[i]) begin
        mem_id[i][wptr[i]]   <= src_id[i*ID_W +: ID_W];
        mem_data[i][wptr[i]] <= src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        cnt[i]  <= '0;
        rptr[i] <= '0;
        wptr[i] <= '0;
      end
      cmp_valid <= '0;
      cmp_id    <= '0;
      cmp_data  <= '0;
      cmp_src   <= '0;
      rr_ptr    <= '0;
    end else if (flash) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        cnt[i]  <= '0;
        rptr[i] <= '0;
        wptr[i] <= '0;
      end
      cmp_valid <= '0;
      rr_ptr    <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (push[i])  wptr[i] <= wptr[i] + PTR_W'(1);
        if (grant[i]) rptr[i] <= rptr[i] + PTR_W'(1);
        if (push[i] && !grant[i])      cnt[i] <= cnt[i] + CNT_W'(1);
        else if (grant[i] && !push[i]) cnt[i] <= cnt[i] - CNT_W'(1);
      end
      for (int unsigned b = 0; b < NUM_BUS; b++) begin
        cmp_valid[b] <= bus_used[b];
        // Unused buses keep their last id/data/src.
        if (bus_used[b]) begin
          cmp_id[b*ID_W +: ID_W]       <= head_id[bus_sel[b]];
          cmp_data[b*DATA_W +: DATA_W] <= head_data[bus_sel[b]];
          cmp_src[b*SRC_W +: SRC_W]    <= bus_sel[b];
        end
      end
      rr_ptr <= next_rr;
    end
  end

endmodule

// File: tb/tb_result_arbiter.sv
// Randomized bench for result_arbiter against a queue-based reference model.
module tb_result_arbiter;

  localparam int NUM_SRC = 5;
  localparam int NUM_BUS = 2;
  localparam int DEPTH   = 4;
  localparam int ID_W    = 8;
  localparam int DATA_W  = 32;
  localparam int SRC_W   = $clog2(NUM_SRC);

  logic                        clock;
  logic                        reset;
  logic                        flash;
  logic [NUM_SRC-1:0]          src_valid;
  logic [NUM_SRC*ID_W-1:0]     src_id;
  logic [NUM_SRC*DATA_W-1:0]   src_data;
  logic [NUM_SRC-1:0]          src_ready;
  logic [NUM_BUS-1:0]          cmp_valid;
  logic [NUM_BUS*ID_W-1:0]     cmp_id;
  logic [NUM_BUS*DATA_W-1:0]   cmp_data;
  logic [NUM_BUS*SRC_W-1:0]    cmp_src;

  result_arbiter #(
    .NUM_SRC(NUM_SRC), .NUM_BUS(NUM_BUS), .DEPTH(DEPTH), .ID_W(ID_W), .DATA_W(DATA_W)
  ) dut (
    .clock(clock), .reset(reset), .flash(flash),
    .src_valid(src_valid), .src_id(src_id), .src_data(src_data), .src_ready(src_ready),
    .cmp_valid(cmp_valid), .cmp_id(cmp_id), .cmp_data(cmp_data), .cmp_src(cmp_src)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: one queue per source, plain round-robin scan.
  typedef struct packed { logic [ID_W-1:0] id; logic [DATA_W-1:0] data; } ent_t;
  ent_t q [NUM_SRC][$];
  int   rr;
  logic [NUM_BUS-1:0] e_valid;
  logic [ID_W-1:0]    e_id   [NUM_BUS];
  logic [DATA_W-1:0]  e_data [NUM_BUS];
  int                 e_src  [NUM_BUS];

  task automatic model_reset();
    for (int i = 0; i < NUM_SRC; i++) q[i].delete();
    rr = 0;
    e_valid = '0;
    for (int b = 0; b < NUM_BUS; b++) begin
      e_id[b] = '0; e_data[b] = '0; e_src[b] = 0;
    end
  endtask

  task automatic model_edge();
    bit acc [NUM_SRC];
    int nb, last, s;
    ent_t e;
    if (flash) begin
      for (int i = 0; i < NUM_SRC; i++) q[i].delete();
      e_valid = '0;
      rr = 0;
      return;
    end
    for (int i = 0; i < NUM_SRC; i++) acc[i] = src_valid[i] && (q[i].size() < DEPTH);
    nb = 0; last = -1;
    for (int j = 0; j < NUM_SRC; j++) begin
      s = (rr + j) % NUM_SRC;
      if (q[s].size() > 0 && nb < NUM_BUS) begin
        e = q[s].pop_front();
        e_valid[nb] = 1'b1; e_id[nb] = e.id; e_data[nb] = e.data; e_src[nb] = s;
        nb++; last = s;
      end
    end
    for (int b = nb; b < NUM_BUS; b++) e_valid[b] = 1'b0;
    if (last >= 0) rr = (last + 1) % NUM_SRC;
    for (int i = 0; i < NUM_SRC; i++)
      if (acc[i]) begin
        e.id = src_id[i*ID_W +: ID_W];
        e.data = src_data[i*DATA_W +: DATA_W];
        q[i].push_back(e);
      end
  endtask

  task automatic compare_all(input string ph);
    logic [NUM_SRC-1:0] er;
    for (int b = 0; b < NUM_BUS; b++) begin
      check($sformatf("%s valid%0d", ph, b), 64'(cmp_valid[b]), 64'(e_valid[b]));
      check($sformatf("%s id%0d", ph, b),    64'(cmp_id[b*ID_W +: ID_W]), 64'(e_id[b]));
      check($sformatf("%s data%0d", ph, b),  64'(cmp_data[b*DATA_W +: DATA_W]), 64'(e_data[b]));
      check($sformatf("%s src%0d", ph, b),   64'(cmp_src[b*SRC_W +: SRC_W]), 64'(e_src[b]));
    end
    for (int i = 0; i < NUM_SRC; i++) er[i] = (q[i].size() != DEPTH);
    check($sformatf("%s ready", ph), 64'(src_ready), 64'(er));
  endtask

  task automatic cycle(input string ph);
    @(posedge clock);
    #1;
    if (reset) model_edge();
    compare_all(ph);
  endtask

  task automatic idle_inputs();
    src_valid = '0; src_id = '0; src_data = '0; flash = 1'b0;
  endtask

  task automatic set_src(input int i, input logic [ID_W-1:0] id, input logic [DATA_W-1:0] d);
    src_valid[i] = 1'b1;
    src_id[i*ID_W +: ID_W] = id;
    src_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic rand_inputs(input int pct_valid, input int pct_flash);
    for (int i = 0; i < NUM_SRC; i++) begin
      src_valid[i] = ($urandom_range(99) < pct_valid);
      src_id[i*ID_W +: ID_W] = ID_W'($urandom);
      src_data[i*DATA_W +: DATA_W] = $urandom;
    end
    flash = ($urandom_range(99) < pct_flash);
  endtask

  task automatic single_result(input string ph);
    idle_inputs();
    set_src(2, 8'h21, 32'hDEADBEEF);
    cycle({ph, " e0"});
    check({ph, " e0 valid"}, 64'(cmp_valid), 64'(0));
    idle_inputs();
    cycle({ph, " e1"});
    check({ph, " e1 valid"}, 64'(cmp_valid), 64'(2'b01));
    check({ph, " e1 id"},    64'(cmp_id[0 +: ID_W]), 64'(8'h21));
    check({ph, " e1 data"},  64'(cmp_data[0 +: DATA_W]), 64'(32'hDEADBEEF));
    check({ph, " e1 src"},   64'(cmp_src[0 +: SRC_W]), 64'(2));
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    model_reset();
    #12;
    compare_all("reset");
    @(negedge clock);
    reset = 1'b1;

    single_result("single");

    // Contention: all sources push ids 10..14 together (rr_ptr is 3 here).
    idle_inputs();
    cycle("pre");
    idle_inputs();
    for (int i = 0; i < NUM_SRC; i++) set_src(i, ID_W'(10 + i), 32'(100 + i));
    cycle("cont e0");
    idle_inputs();
    for (int k = 0; k < 4; k++) cycle($sformatf("cont e%0d", k + 1));

    // Full FIFO: source 0 kept valid while others saturate the buses.
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < NUM_SRC; i++) set_src(i, ID_W'($urandom), $urandom);
      cycle($sformatf("full %0d", k));
    end
    idle_inputs();
    for (int k = 0; k < 12; k++) cycle("drain");

    // Wrap-around: source 1 streams 10 entries with no contention.
    for (int k = 0; k < 10; k++) begin
      idle_inputs();
      set_src(1, ID_W'(8'h40 + k), 32'(k * 7));
      cycle($sformatf("wrap %0d", k));
    end
    idle_inputs();
    for (int k = 0; k < 3; k++) cycle("wrap tail");

    // Flash with buffered entries and a simultaneous push.
    idle_inputs();
    set_src(0, 8'h01, 32'h1); set_src(3, 8'h03, 32'h3); set_src(4, 8'h04, 32'h4);
    cycle("fl load");
    idle_inputs();
    set_src(2, 8'h02, 32'h2);
    flash = 1'b1;
    cycle("fl edge");
    check("fl valid", 64'(cmp_valid), 64'(0));
    check("fl ready", 64'(src_ready), 64'({NUM_SRC{1'b1}}));
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      cycle("fl after");
      check("fl stale", 64'(cmp_valid), 64'(0));
    end

    // Randomized phases with varying load and occasional flash.
    for (int ph = 0; ph < 4; ph++) begin
      for (int k = 0; k < 300; k++) begin
        rand_inputs(20 + ph * 25, 3);
        cycle($sformatf("rand%0d", ph));
      end
    end

    // Async reset while both buses are busy.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < NUM_SRC; i++) set_src(i, ID_W'($urandom), $urandom);
      cycle("busy");
    end
    check("busy both", 64'(cmp_valid), 64'(2'b11));
    #2;
    reset = 1'b0;
    #1;
    check("arst valid", 64'(cmp_valid), 64'(0));
    check("arst id",    64'(cmp_id), 64'(0));
    model_reset();
    idle_inputs();
    @(negedge clock);
    compare_all("arst held");
    reset = 1'b1;
    single_result("post rst");

    idle_inputs();
    repeat (2) @(posedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/result_arbiter.md
Name: result_arbiter

Overview:
Parametrised successor to the core's result queue. Collects execution results from NUM_SRC reservation-station/unit ports into per-source FIFOs. Drains them onto NUM_BUS parallel completion broadcast buses each cycle, using rotating round-robin priority. The buses feed the commit queue and RS wakeup logic. Supports pipeline flash on branch miss and per-source backpressure.

Parameters:
NUM_SRC, 5, number of result sources (ALU, BU, FPU, UART, MEM); 2..8
NUM_BUS, 2, number of completion buses driven per cycle; 1..NUM_SRC
DEPTH, 4, entries per source FIFO; power of 2, >=2
ID_W, 8, commit-queue entry id width
DATA_W, 32, result data width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
flash  in  1  synchronous pipeline flush (reset or branch miss)
src_valid  in  NUM_SRC  bit i: source i presents a result
src_id  in  NUM_SRC*ID_W  source i id at [i*ID_W +: ID_W]
src_data  in  NUM_SRC*DATA_W  source i data at [i*DATA_W +: DATA_W]
src_ready  out  NUM_SRC  bit i: FIFO i can accept an entry
cmp_valid  out  NUM_BUS  bus b carries a completion
cmp_id  out  NUM_BUS*ID_W  bus b id
cmp_data  out  NUM_BUS*DATA_W  bus b data
cmp_src  out  NUM_BUS*$clog2(NUM_SRC)  bus b originating source index

Behaviour:
- Reset (reset=0, async):
  - all FIFOs empty
  - cmp_valid=0; cmp_id/data/src=0
  - rr_ptr=0
  - src_ready=all ones once reset deasserts
- Push:
  - Source i's entry is written at the rising edge where src_valid[i] & src_ready[i].
  - src_ready[i] = (count_i != DEPTH), taken from registered count only. A full FIFO does not accept a push in the same cycle it pops.
  - src_valid while not ready: entry ignored. The source holds it; no loss inside this block.
- Grant (combinational from registered state):
  - Scan sources cyclically starting at rr_ptr.
  - The first NUM_BUS non-empty FIFOs are granted; the k-th granted source goes to bus k.
  - At most one pop per source per cycle.
- Output:
  - cmp_* registered from the granted FIFO heads at the same edge that pops them.
  - cmp_valid[b]=0 for unused buses; their id/data/src hold their previous values.
  - No backpressure on completion buses.
- Latency:
  - An entry pushed at edge k appears on cmp at the earliest in the cycle after edge k+1.
  - No same-cycle bypass.
- rr_ptr:
  - If any grant: rr_ptr <= (last granted index + 1) mod NUM_SRC.
  - Else: unchanged.
- Simultaneous push and pop on one FIFO: both happen, count unchanged. Read/write pointers wrap mod DEPTH.
- Ordering: per-source FIFO order is preserved. No ordering is guaranteed across sources.
- flash=1 at an edge:
  - all FIFOs emptied; pushes in that cycle dropped
  - cmp_valid<=0
  - rr_ptr<=0
  - flash has priority over push and grant
- Reset mid-operation: immediate async clear, identical to the reset state.
- Invariant: count_i <= DEPTH always.
- Assertion: src_valid while reset=0 is ignored.

Test Plan:
1. Single result: src 2 pushes id=0x21 data=0xDEADBEEF at edge 0 → cycle after edge 1: cmp_valid=2'b01, bus0 id=0x21, data=0xDEADBEEF, src=2; rr_ptr=3.
2. Contention (NUM_BUS=2): all 5 sources push ids 10..14 at edge 0, rr_ptr=0 → after edge 1: {10,11}; after edge 2: {12,13}; after edge 3: {14,–} with cmp_valid=2'b01; rr_ptr goes 2→4→0.
3. Full: source 0 pushes 4 entries while bus stalled by higher-priority traffic → src_ready[0]=0 once count=4. A 5th src_valid is not accepted; it is accepted the cycle after one pop.
4. Wrap-around: source 1 streams 10 entries, one per cycle, with no contention → all 10 emerge in order on bus0 with 2-cycle latency; pointers wrap twice.
5. Flash: 3 entries buffered across sources plus a push in the same cycle as flash=1 → next cycle cmp_valid=0, all src_ready=1, rr_ptr=0; no stale entry ever appears afterwards.
6. Async reset: assert reset=0 between edges while cmp_valid=2'b11 → cmp_valid drops immediately, without waiting for a clock edge; post-release, the first push behaves as in scenario 1.
